// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch control slice: FSM state codes and
// the default debounce window (10 ms at 100 MHz).
package stopwatch_ctrl_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_CLEAR = 2'b10
    } sw_state_e;

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// One pushbutton front end: 2-flop synchronizer, stable-level debouncer and
// a one-cycle registered press pulse on each accepted 0->1 transition.
module btn_debounce
    import stopwatch_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int unsigned     CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Accepting the new level; a rising acceptance is the press.
                level <= sync2;
                cnt   <= '0;
                press <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/stop/clear controller driving an external up-counter.
// Optional lap/display-freeze button enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_btn_run,
    input  logic       i_btn_clr,
`ifdef STOPWATCH_LAP_EN
    input  logic       i_btn_lap,
`endif
    output logic       o_run_on,
    output logic       o_clr_on,
`ifdef STOPWATCH_LAP_EN
    output logic       o_lap_hold,
`endif
    output logic [1:0] o_state
);

    sw_state_e state;
    sw_state_e state_next;
    logic      run_press;
    logic      clr_press;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
        .clk   (clk),
        .reset (reset),
        .btn   (i_btn_run),
        .press (run_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
        .clk   (clk),
        .reset (reset),
        .btn   (i_btn_clr),
        .press (clr_press)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_STOP;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = ST_STOP;
        case (state)
            ST_STOP: begin
                // Clear wins when both presses land in the same cycle.
                if (clr_press)      state_next = ST_CLEAR;
                else if (run_press) state_next = ST_RUN;
                else                state_next = ST_STOP;
            end
            ST_RUN:   state_next = run_press ? ST_STOP : ST_RUN;
            ST_CLEAR: state_next = ST_STOP;
            default:  state_next = ST_STOP;
        endcase
    end

    assign o_run_on = (state == ST_RUN);
    assign o_clr_on = (state == ST_CLEAR);
    assign o_state  = state;

`ifdef STOPWATCH_LAP_EN
    logic lap_press;
    logic lap_hold;
    logic lap_hold_next;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap (
        .clk   (clk),
        .reset (reset),
        .btn   (i_btn_lap),
        .press (lap_press)
    );

    always_comb begin
        lap_hold_next = lap_hold;
        if (lap_press && (state == ST_RUN))       lap_hold_next = ~lap_hold;
        else if (lap_press && (state == ST_STOP)) lap_hold_next = 1'b0;
        if (state_next == ST_CLEAR)               lap_hold_next = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lap_hold <= 1'b0;
        end else begin
            lap_hold <= lap_hold_next;
        end
    end

    assign o_lap_hold = lap_hold;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4: a window-based
// reference model queues expected outputs per edge, a monitor compares them.
module tb_stopwatch_ctrl;

    localparam int D = 4;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       i_btn_run;
    logic       i_btn_clr;
    logic       i_btn_lap;
    logic       o_run_on;
    logic       o_clr_on;
    logic       lap_act;
    logic [1:0] o_state;

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_btn_run  (i_btn_run),
        .i_btn_clr  (i_btn_clr),
`ifdef STOPWATCH_LAP_EN
        .i_btn_lap  (i_btn_lap),
        .o_lap_hold (lap_act),
`endif
        .o_run_on   (o_run_on),
        .o_clr_on   (o_clr_on),
        .o_state    (o_state)
    );
`ifndef STOPWATCH_LAP_EN
    assign lap_act = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       run_on;
        logic       clr_on;
        logic [1:0] st;
        logic       lap;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state: raw-sample ring per button, accepted levels,
    // edge index of last acceptance, presses awaiting the FSM.
    bit   hist [3][16];
    bit   acc  [3];
    int   last_flip [3];
    bit   pend [3];
    int   k;
    int   st;
    bit   lap;

    task automatic model_clear();
        k = 0;
        st = 0;
        lap = 1'b0;
        for (int b = 0; b < 3; b++) begin
            acc[b] = 1'b0;
            last_flip[b] = 0;
            pend[b] = 1'b0;
        end
    endtask

    task automatic model_step(input logic [2:0] raw);
        bit newp [3];
        bit all_diff;
        bit v;
        int j;
        int prev;
        k++;
        for (int b = 0; b < 3; b++) begin
            hist[b][k % 16] = raw[b];
            newp[b] = 1'b0;
            // Level accepted once the D samples seen through the 2-stage
            // synchronizer all disagree and D edges passed since last change.
            if (k - last_flip[b] >= D) begin
                all_diff = 1'b1;
                for (int i = 2; i <= D + 1; i++) begin
                    j = k - i;
                    v = (j >= 1) ? hist[b][j % 16] : 1'b0;
                    if (v == acc[b]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    acc[b] = ~acc[b];
                    last_flip[b] = k;
                    newp[b] = acc[b];
                end
            end
        end
        prev = st;
        case (prev)
            0:       st = pend[1] ? 2 : (pend[0] ? 1 : 0);
            1:       st = pend[0] ? 0 : 1;
            default: st = 0;
        endcase
        if (LAP_EN) begin
            if (prev == 1 && pend[2])      lap = ~lap;
            else if (prev == 0 && pend[2]) lap = 1'b0;
            if (st == 2)                   lap = 1'b0;
        end
        for (int b = 0; b < 3; b++) pend[b] = newp[b];
    endtask

    initial begin : model
        logic [2:0] rs;
        logic       rst_e;
        exp_t       e;
        model_clear();
        forever begin
            @(posedge clk);
            rs    = {i_btn_lap, i_btn_clr, i_btn_run};
            rst_e = reset;
            @(negedge clk);
            if (!reset || !rst_e) model_clear();
            else                  model_step(rs);
            e.run_on = (st == 1);
            e.clr_on = (st == 2);
            e.st     = 2'(st);
            e.lap    = lap;
            exp_q.push_back(e);
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_empty at %0t: no expected entry", $time);
            end else begin
                e = exp_q.pop_front();
                if ({o_run_on, o_clr_on, o_state, lap_act} !== e) begin
                    miscompares++;
                    $display("FAIL outputs at %0t: got run_on=%0b clr_on=%0b state=%b lap=%0b, expected run_on=%0b clr_on=%0b state=%b lap=%0b",
                             $time, o_run_on, o_clr_on, o_state, lap_act,
                             e.run_on, e.clr_on, e.st, e.lap);
                end
            end
        end
    end

    task automatic hold(input logic r, input logic c, input logic l, input int n);
        @(posedge clk);
        #2;
        i_btn_run = r;
        i_btn_clr = c;
        i_btn_lap = l;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic press(input logic r, input logic c, input logic l);
        hold(r, c, l, 12);
        hold(1'b0, 1'b0, 1'b0, 10);
    endtask

    // Called just after the stimulus edge that starts the measured press.
    task automatic measure_run(input string name);
        int n;
        n = 0;
        while (!o_run_on && n < 40) begin
            @(posedge clk);
            n++;
            #1;
        end
        vectors++;
        if (n != D + 3) begin
            miscompares++;
            $display("FAIL %s: o_run_on rose after %0d edges, expected %0d", name, n, D + 3);
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (n) @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        reset = 1'b0;
        i_btn_run = 1'b0;
        i_btn_clr = 1'b0;
        i_btn_lap = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        hold(1'b0, 1'b0, 1'b0, 4);

        // clean run press, latency from raw edge
        @(posedge clk);
        #2;
        i_btn_run = 1'b1;
        measure_run("run_latency");
        hold(1'b1, 1'b0, 1'b0, 13);
        hold(1'b0, 1'b0, 1'b0, 10);

        // back to STOP, then bouncy press 1-0-1 with 2-cycle pulses
        press(1'b1, 1'b0, 1'b0);
        hold(1'b1, 1'b0, 1'b0, 2);
        hold(1'b0, 1'b0, 1'b0, 2);
        hold(1'b1, 1'b0, 1'b0, 20);
        hold(1'b0, 1'b0, 1'b0, 10);

        // lap toggles in RUN, clr ignored in RUN, stop, lap then clr in STOP
        press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b1, 1'b0);

        // simultaneous run and clr in STOP
        press(1'b1, 1'b1, 1'b0);

        // RUN with button held, reset mid-RUN, button held through release
        hold(1'b1, 1'b0, 1'b0, 15);
        @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        measure_run("run_after_reset");
        hold(1'b1, 1'b0, 1'b0, 8);
        hold(1'b0, 1'b0, 1'b0, 10);

        // randomized bouncy traffic with occasional resets
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 29) == 0) begin
                do_reset(int'($urandom_range(1, 3)));
            end else begin
                hold(logic'($urandom_range(0, 2) == 0),
                     logic'($urandom_range(0, 2) == 0),
                     logic'($urandom_range(0, 2) == 0),
                     int'($urandom_range(1, 10)));
            end
        end

        hold(1'b0, 1'b0, 1'b0, 12);
        repeat (2) @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
